ex_muldiv_seq: RTL

//  Iterative RV32M multiply/divide sequencer beside the EX-stage ALU. Accepts one M-extension op

---
 rtl/ex_muldiv_seq.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/ex_muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer that sits beside the EX-stage ALU.
// One bit per cycle: shift-add for multiplies, restoring division for divides.
// Signed operands are converted to magnitudes on entry and fixed up at the end.
module ex_muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CALC  = 2'd1;
  localparam logic [1:0] FIXUP = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [2:0]       op_q;
  logic             neg_res;
  logic             neg_rem;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] res_q;

  logic             a_signed, b_signed, sign_a, sign_b;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic             special;
  logic [WIDTH-1:0] special_res;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_trial;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] fix_res;

  // Operand decode in IDLE: signedness, magnitudes and the divide corner cases
  always_comb begin
    a_signed    = (op == 3'd0) || (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    b_signed    = (op == 3'd0) || (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    sign_a      = a_signed & a[WIDTH-1];
    sign_b      = b_signed & b[WIDTH-1];
    a_abs       = sign_a ? -a : a;
    b_abs       = sign_b ? -b : b;
    special     = 1'b0;
    special_res = '0;
    if (op[2]) begin
      if (b == '0) begin
        special     = 1'b1;
        special_res = op[1] ? a : ALL_ONES;
      end else if (!op[0] && (a == MIN_NEG) && (b == ALL_ONES)) begin
        special     = 1'b1;
        special_res = op[1] ? '0 : MIN_NEG;
      end
    end
  end

  // One iteration of shift-add multiply and of restoring divide, plus the final sign fix-up
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, b_mag} : '0);
    div_trial = {hi, lo[WIDTH-1]} - {1'b0, b_mag};
    prod_fix  = neg_res ? -{hi, lo} : {hi, lo};
    if (op_q[2]) begin
      if (op_q[1]) fix_res = neg_rem ? -hi : hi;
      else         fix_res = neg_res ? -lo : lo;
    end else if (op_q == 3'd0) begin
      fix_res = prod_fix[WIDTH-1:0];
    end else begin
      fix_res = prod_fix[2*WIDTH-1:WIDTH];
    end
  end

  // Sequencer FSM and datapath registers; flush returns to IDLE from any state
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      count   <= '0;
      op_q    <= '0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      b_mag   <= '0;
      res_q   <= '0;
    end else if (flush) begin
      state <= IDLE;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q    <= op;
            neg_res <= sign_a ^ sign_b;
            neg_rem <= sign_a;
            b_mag   <= b_abs;
            count   <= '0;
            if (special) begin
              res_q <= special_res;
              state <= DONE;
            end else begin
              hi    <= '0;
              lo    <= a_abs;
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (op_q[2]) begin
            if (!div_trial[WIDTH]) begin
              hi <= div_trial[WIDTH-1:0];
              lo <= {lo[WIDTH-2:0], 1'b1};
            end else begin
              hi <= {hi[WIDTH-2:0], lo[WIDTH-1]};
              lo <= {lo[WIDTH-2:0], 1'b0};
            end
          end else begin
            hi <= mul_sum[WIDTH:1];
            lo <= {mul_sum[0], lo[WIDTH-1:1]};
          end
          count <= count + 1'b1;
          if (count == CW'(WIDTH-1)) state <= FIXUP;
        end
        FIXUP: begin
          res_q <= fix_res;
          state <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Pipeline hold and result handshake; a flush cycle never stalls or completes
  always_comb begin
    stall  = ~flush & (((state == IDLE) & start) | (state == CALC) | (state == FIXUP));
    done   = ~flush & (state == DONE);
    result = res_q;
  end

endmodule
